// File: rtl/twiddle_addr_gen_pkg.sv
// rtl/twiddle_addr_gen_pkg.sv - shared FFT sizing parameters and twiddle address helpers
// Purpose : single home for DATA_WIDTH / LOG2N defaults and the twiddle exponent math.
// Contents: DATA_WIDTH, LOG2N, STAGE_MAX, JW; clamp_stage(), twiddle_exp().
package twiddle_addr_gen_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int LOG2N      = 5;
  localparam int STAGE_MAX  = LOG2N - 1;   // last valid stage index
  localparam int JW         = LOG2N - 1;   // butterfly counter / ROM address width

  // Out-of-range stage requests run as the final stage.
  function automatic logic [2:0] clamp_stage(input logic [2:0] s);
    return (s > 3'(STAGE_MAX)) ? 3'(STAGE_MAX) : s;
  endfunction

  // Exponent k = (j mod 2^s) << (JW - s): low s bits of j, left-justified.
  function automatic logic [JW-1:0] twiddle_exp(input logic [JW-1:0] j, input logic [2:0] s);
    logic [JW-1:0] mask;
    mask = JW'((32'd1 << s) - 32'd1);
    return (j & mask) << (3'(JW) - s);
  endfunction

endpackage

// File: rtl/twiddle_addr_gen_pipe.sv
// rtl/twiddle_addr_gen_pipe.sv - fixed-depth {valid,data} delay line
// Purpose : delays a valid flag and its payload by DEPTH cycles; payload holds when invalid.
// Ports   : clk, rst_n (async active-low), valid_i/data_i in, valid_o/data_o out.
module pipe_delay #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic [DEPTH-1:0] v_q;
  logic [WIDTH-1:0] d_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int i = 0; i < DEPTH; i++) d_q[i] <= '0;
    end else begin
      v_q <= {v_q[DEPTH-2:0], valid_i};
      // Each stage only loads when a valid beat moves into it, so data_o
      // keeps the last delivered beat during gaps.
      if (valid_i) d_q[0] <= data_i;
      for (int i = 1; i < DEPTH; i++) begin
        if (v_q[i-1]) d_q[i] <= d_q[i-1];
      end
    end
  end

  assign valid_o = v_q[DEPTH-1];
  assign data_o  = d_q[DEPTH-1];

endmodule

// File: rtl/twiddle_addr_gen.sv
// rtl/twiddle_addr_gen.sv - per-stage FFT twiddle ROM address generator
// Purpose : walks 2^(LOG2N-1) butterflies of one stage, drives the twiddle ROM address
//           and delays the operand pair to line up with the 2-cycle ROM output.
// Ports   : clk, rst_n (async active-low); start, stage[2:0], in_valid, in_data in;
//           rom_en, rom_addr, out_valid, out_data, busy, done out.
module twiddle_addr_gen
  import twiddle_addr_gen_pkg::*;
#(
  parameter int DATA_WIDTH = twiddle_addr_gen_pkg::DATA_WIDTH,
  parameter int LOG2N      = twiddle_addr_gen_pkg::LOG2N
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [2:0]              stage,
  input  logic                    in_valid,
  input  logic [4*DATA_WIDTH-1:0] in_data,
  output logic                    rom_en,
  output logic [LOG2N-2:0]        rom_addr,
  output logic                    out_valid,
  output logic [4*DATA_WIDTH-1:0] out_data,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [LOG2N-2:0] J_LAST = '1;

  state_t          state_q, state_d;
  logic [LOG2N-2:0] j_q, j_d;
  logic [2:0]       stage_q, stage_d;
  logic             drain_q, drain_d;   // second DRAIN cycle marker
  logic             accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      j_q     <= '0;
      stage_q <= '0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      stage_q <= stage_d;
      drain_q <= drain_d;
    end
  end

  assign accept = (state_q == S_RUN) && in_valid;

  always_comb begin
    state_d  = state_q;
    j_d      = j_q;
    stage_d  = stage_q;
    drain_d  = drain_q;
    rom_en   = accept;
    rom_addr = accept ? twiddle_exp(j_q, stage_q) : '0;
    busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
    done     = (state_q == S_DONE);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          stage_d = clamp_stage(stage);
          j_d     = '0;
        end
      end
      S_RUN: begin
        if (accept) begin
          j_d = j_q + 1'b1;   // wraps to 0 after the last butterfly
          if (j_q == J_LAST) begin
            state_d = S_DRAIN;
            drain_d = 1'b0;
          end
        end
      end
      S_DRAIN: begin
        // Two cycles let the final beats clear the ROM-latency pipe.
        drain_d = 1'b1;
        if (drain_q) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  pipe_delay #(
    .WIDTH(4*DATA_WIDTH),
    .DEPTH(2)
  ) u_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid_i(accept),
    .data_i (in_data),
    .valid_o(out_valid),
    .data_o (out_data)
  );

endmodule

// File: tb/tb_twiddle_addr_gen.sv
// tb/tb_twiddle_addr_gen.sv - self-checking bench for twiddle_addr_gen
module tb_twiddle_addr_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  stage = 3'd0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = 64'd0;
  logic        rom_en;
  logic [3:0]  rom_addr;
  logic        out_valid;
  logic [63:0] out_data;
  logic        busy;
  logic        done;

  twiddle_addr_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stage(stage),
    .in_valid(in_valid), .in_data(in_data),
    .rom_en(rom_en), .rom_addr(rom_addr), .out_valid(out_valid),
    .out_data(out_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a pass is "beats taken so far" plus "cycles since the
  // sixteenth beat"; outputs follow from those counts.
  bit          m_active = 0;
  int          m_beats = 0;
  int          m_post = 0;
  int          m_s = 0;
  bit          hv1 = 0, hv2 = 0;
  logic [63:0] hd1 = 0, hd2 = 0;

  always @(negedge rst_n) begin
    m_active = 0; m_beats = 0; m_post = 0; m_s = 0;
    hv1 = 0; hv2 = 0; hd1 = 0; hd2 = 0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      bit acc;
      acc = m_active && m_beats < 16 && in_valid;
      hv2 = hv1;
      if (hv1) hd2 = hd1;
      hv1 = acc;
      if (acc) hd1 = in_data;
      if (!m_active) begin
        if (start) begin
          m_active = 1; m_beats = 0; m_post = 0;
          m_s = (stage > 4) ? 4 : int'(stage);
        end
      end else if (m_beats < 16) begin
        if (acc) m_beats++;
      end else if (m_post == 2) begin
        m_active = 0;
      end else begin
        m_post++;
      end
    end
  end

  int cyc = 0;
  int done_cyc = -1;
  int last_beat_cyc = -1;
  int capq[$];

  always @(negedge clk) begin
    bit e_acc;
    int e_addr;
    e_acc  = rst_n && m_active && m_beats < 16 && in_valid;
    e_addr = e_acc ? ((m_beats % (1 << m_s)) * (16 >> m_s)) : 0;
    chk("rom_en", 64'(rom_en), 64'(e_acc));
    chk("rom_addr", 64'(rom_addr), 64'(e_addr));
    chk("out_valid", 64'(out_valid), 64'(hv2));
    chk("out_data", out_data, hd2);
    chk("busy", 64'(busy), 64'(m_active && (m_beats < 16 || m_post < 2)));
    chk("done", 64'(done), 64'(m_active && m_beats == 16 && m_post == 2));
    if (rom_en) begin
      capq.push_back(int'(rom_addr));
      last_beat_cyc = cyc;
    end
    if (done) done_cyc = cyc;
    cyc++;
  end

  task automatic feed(input int nbeats, input bit gaps, input bit mid_start);
    int n = 0;
    int k = 0;
    while (n < nbeats && k < 100) begin
      in_valid = !(gaps && (k % 3 == 2));
      in_data  = {$urandom, $urandom};
      start    = mid_start && (k == 5);
      if (in_valid) n++;
      k++;
      @(posedge clk); #1;
    end
    in_valid = 0;
    start = 0;
  endtask

  task automatic begin_pass(input logic [2:0] stg);
    capq.delete();
    done_cyc = -1;
    @(posedge clk); #1;
    start = 1; stage = stg; in_valid = 0;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic finish_pass(input string name, input int exp_addr[16]);
    for (int t = 0; t < 10 && done_cyc < 0; t++) @(posedge clk);
    #1;
    chk({name, "_done_seen"}, 64'(done_cyc >= 0), 64'd1);
    chk({name, "_done_lat"}, 64'(done_cyc - last_beat_cyc), 64'd3);
    chk({name, "_nbeats"}, 64'(capq.size()), 64'd16);
    for (int i = 0; i < 16 && i < capq.size(); i++)
      chk({name, "_addr"}, 64'(capq[i]), 64'(exp_addr[i]));
    repeat (2) @(posedge clk);
    #1;
  endtask

  int e0[16] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
  int e4[16] = '{0,1,2,3,4,5,6,7,8,9,10,11,12,13,14,15};
  int e2[16] = '{0,4,8,12,0,4,8,12,0,4,8,12,0,4,8,12};
  int e1[16] = '{0,8,0,8,0,8,0,8,0,8,0,8,0,8,0,8};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rom_en", 64'(rom_en), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    rst_n = 1;

    begin_pass(3'd0); feed(16, 0, 0); finish_pass("stage0", e0);
    begin_pass(3'd4); feed(16, 0, 0); finish_pass("stage4", e4);
    begin_pass(3'd2); feed(16, 1, 0); finish_pass("stage2_gaps", e2);
    begin_pass(3'd7); feed(16, 0, 1); finish_pass("stage7_restart", e4);

    // Abort a stage-1 pass after eight beats with an asynchronous reset.
    begin_pass(3'd1);
    feed(8, 0, 0);
    in_valid = 1;
    #2 rst_n = 0;
    #1;
    chk("abort_rom_en", 64'(rom_en), 64'd0);
    chk("abort_rom_addr", 64'(rom_addr), 64'd0);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_out_data", out_data, 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    in_valid = 0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_done", 64'(done_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
    begin_pass(3'd1); feed(16, 0, 0); finish_pass("stage1_after_reset", e1);

    // in_valid while idle must not produce ROM reads or outputs.
    capq.delete();
    in_valid = 1;
    repeat (5) @(posedge clk);
    #1;
    in_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_no_rom", 64'(capq.size()), 64'd0);
    chk("idle_out_valid", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule

// File: doc/twiddle_addr_gen.md
TWIDDLE_ADDR_GEN -- requirements
Module: twiddle_addr_gen

Interface
REQ-001 Parameter DATA_WIDTH, default 16 (from parameters.vh), real/imag component width.
REQ-002 Parameter LOG2N, default 5, FFT size exponent; 2^(LOG2N-1)=16 butterflies per stage.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  one-cycle pulse; latches stage and begins a stage pass.
REQ-006 stage  in  3  FFT stage index 0..4, sampled only on an accepted start.
REQ-007 in_valid  in  1  butterfly operand pair present on in_data.
REQ-008 in_data  in  4*DATA_WIDTH  operand pair {A,B}, each complex {re,im}.
REQ-009 rom_en  out  1  enable to twiddle ROM.
REQ-010 rom_addr  out  4  twiddle exponent k to twiddle ROM.
REQ-011 out_valid  out  1  out_data aligned with ROM twiddle output.
REQ-012 out_data  out  4*DATA_WIDTH  in_data delayed to match ROM latency.
REQ-013 busy  out  1  high in RUN and DRAIN.
REQ-014 done  out  1  one-cycle pulse when a pass completes.

Function
REQ-015 FSM states IDLE, RUN, DRAIN, DONE.
REQ-016 IDLE->RUN on start=1; stage latched (values 5..7 clamp to 4); butterfly counter j cleared to 0.
REQ-017 start while not IDLE is ignored.
REQ-018 In RUN, a beat is accepted on each cycle with in_valid=1; gaps (in_valid=0) hold j.
REQ-019 in_valid outside RUN is ignored: no rom_en, no out_valid.
REQ-020 rom_en = accepted beat, combinational; rom_addr = (j mod 2^s) << (4-s), s = latched stage, combinational from j and s.
REQ-021 rom_addr is 0 when rom_en=0.
REQ-022 j increments by 1 per accepted beat, 4 bits; accepting beat j=15 moves RUN->DRAIN; j wraps to 0.
REQ-023 DRAIN lasts exactly 2 cycles, then DONE; DONE lasts 1 cycle (done=1), then IDLE.
REQ-024 out_valid/out_data are in_valid-accepted/in_data delayed exactly 2 clk cycles, matching 2-cycle ROM read latency (registered read + output register).
REQ-025 out_data is held (not cleared) when out_valid=0.
REQ-026 No backpressure: every accepted beat appears on out_valid exactly 2 cycles later, including beats accepted on the last RUN cycle.
REQ-027 busy=1 in RUN and DRAIN only; done=1 in DONE only.

Reset
REQ-028 rst_n=0 forces asynchronously: state IDLE, j=0, latched stage=0, delay pipeline valid bits 0, out_data 0, rom_en 0, rom_addr 0, out_valid 0, busy 0, done 0.
REQ-029 Reset mid-RUN or mid-DRAIN aborts the pass; in-flight beats are discarded and no done is emitted.
REQ-030 First start is accepted on the first clk edge after rst_n deasserts.

Structure
REQ-031 DATA_WIDTH and LOG2N live in shared parameters.vh; no local redefinition.
REQ-032 State encodings are localparams inside the module.
REQ-033 One sub-module, pipe_delay (parameters WIDTH, DEPTH=2, async active-low reset), carries {valid,data}.
REQ-034 Estimated size 120-250 RTL lines.

Verification
REQ-035 stage=0, 16 back-to-back beats -> rom_addr 0 for all beats; out_valid 16 cycles starting 2 cycles after first beat; done exactly 3 cycles after last beat.
REQ-036 stage=4, 16 beats -> rom_addr sequence 0,1,2,...,15.
REQ-037 stage=2, 16 beats with in_valid gaps every 3rd cycle -> rom_addr 0,4,8,12 repeated 4 times; j holds across gaps; out_data equals in_data delayed 2 cycles.
REQ-038 stage=7 -> behaves as stage 4; start pulsed during RUN -> no restart, sequence unchanged.
REQ-039 rst_n low after beat 8 of stage 1 -> all outputs 0 asynchronously; no done; next start restarts at j=0, rom_addr 0,8,0,8,...
REQ-040 in_valid=1 while IDLE -> rom_en=0, out_valid stays 0.
